// File: rtl/cgol_pkg.sv
// Shared state type, neighbour-count type and life-rule constants for the
// Game of Life generation engine.
package cgol_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } cgol_state_t;

    // Four bits so that a full neighbourhood of 8 never wraps to 0.
    typedef logic [3:0] nbr_cnt_t;

    localparam nbr_cnt_t BIRTH_CNT = 4'd3;
    localparam nbr_cnt_t SURV_LO   = 4'd2;
    localparam nbr_cnt_t SURV_HI   = 4'd3;

    function automatic logic cell_next(input logic alive, input nbr_cnt_t sum);
        if (alive) return (sum == SURV_LO) || (sum == SURV_HI);
        return sum == BIRTH_CNT;
    endfunction

endpackage

// File: rtl/cgol_gen_engine_if.sv
// Load, control, status and display-read signals of the generation engine.
// Load handshake: a row is transferred on a rising edge where load_valid and
// load_ready are both high; load_valid may be raised at any time and is
// simply not consumed while load_ready is low.
interface cgol_gen_engine_if #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int CNT_W  = 16
);
    localparam int AW = $clog2(HEIGHT);

    logic             load_valid;
    logic             load_ready;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_row;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] gen_count;
    logic             stable;
    logic             extinct;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_row;
    cgol_pkg::cgol_state_t state;

    modport master (
        output load_valid, load_addr, load_row, start, rd_addr,
        input  load_ready, busy, done, gen_count, stable, extinct, rd_row, state
    );

    modport slave (
        input  load_valid, load_addr, load_row, start, rd_addr,
        output load_ready, busy, done, gen_count, stable, extinct, rd_row, state
    );

endinterface

// File: rtl/cgol_row_next.sv
// Combinational next-row generator for one row from its three-row neighbourhood.
// Column wrap-around is enabled by defining CGOL_TORUS_EN.
module cgol_row_next import cgol_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] above_i,
    input  logic [WIDTH-1:0] mid_i,
    input  logic [WIDTH-1:0] below_i,
    output logic [WIDTH-1:0] next_o
);

    // Rows padded by one column each side: ext[c+1] holds column c.
    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] b_ext;
    nbr_cnt_t         sum [WIDTH];

`ifdef CGOL_TORUS_EN
    assign a_ext = {above_i[0], above_i, above_i[WIDTH-1]};
    assign m_ext = {mid_i[0],   mid_i,   mid_i[WIDTH-1]};
    assign b_ext = {below_i[0], below_i, below_i[WIDTH-1]};
`else
    assign a_ext = {1'b0, above_i, 1'b0};
    assign m_ext = {1'b0, mid_i,   1'b0};
    assign b_ext = {1'b0, below_i, 1'b0};
`endif

    always_comb begin
        sum    = '{default: '0};
        next_o = '0;
        for (int c = 0; c < WIDTH; c++) begin
            sum[c] = 4'(a_ext[c]) + 4'(a_ext[c+1]) + 4'(a_ext[c+2])
                   + 4'(m_ext[c])                  + 4'(m_ext[c+2])
                   + 4'(b_ext[c]) + 4'(b_ext[c+1]) + 4'(b_ext[c+2]);
            next_o[c] = cell_next(mid_i[c], sum[c]);
        end
    end

endmodule

// File: rtl/cgol_gen_engine.sv
// Game of Life generation engine: cur/nxt register banks, one row per cycle.
// Row wrap-around (with column wrap in cgol_row_next) enabled by CGOL_TORUS_EN.
module cgol_gen_engine import cgol_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int CNT_W  = 16
) (
    input logic              ph1,
    input logic              reset,
    cgol_gen_engine_if.slave bus
);

    localparam int            AW       = $clog2(HEIGHT);
    localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

    cgol_state_t      state_q, state_d;
    logic [AW-1:0]    row_q, row_d;
    logic             changed_q, changed_d;
    logic             alive_q, alive_d;
    logic [WIDTH-1:0] cur_q [HEIGHT];
    logic [WIDTH-1:0] nxt_q [HEIGHT];
    logic [CNT_W-1:0] gen_q;
    logic             stable_q;
    logic             extinct_q;

    logic             load_we;
    logic             nxt_we;
    logic             commit;
    logic [WIDTH-1:0] above_row, below_row, next_row;

`ifdef CGOL_TORUS_EN
    assign above_row = (row_q == '0)       ? cur_q[LAST_ROW] : cur_q[row_q - 1'b1];
    assign below_row = (row_q == LAST_ROW) ? cur_q[0]        : cur_q[row_q + 1'b1];
`else
    assign above_row = (row_q == '0)       ? '0 : cur_q[row_q - 1'b1];
    assign below_row = (row_q == LAST_ROW) ? '0 : cur_q[row_q + 1'b1];
`endif

    cgol_row_next #(.WIDTH(WIDTH)) u_row_next (
        .above_i (above_row),
        .mid_i   (cur_q[row_q]),
        .below_i (below_row),
        .next_o  (next_row)
    );

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            changed_q <= 1'b0;
            alive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            changed_q <= changed_d;
            alive_q   <= alive_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        changed_d = changed_q;
        alive_d   = alive_q;
        load_we   = 1'b0;
        nxt_we    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                // A load in the same cycle as start takes priority and start is lost.
                if (bus.load_valid) begin
                    load_we = int'(bus.load_addr) < HEIGHT;
                end else if (bus.start) begin
                    state_d   = COMPUTE;
                    row_d     = '0;
                    changed_d = 1'b0;
                    alive_d   = 1'b0;
                end
            end
            COMPUTE: begin
                nxt_we    = 1'b1;
                changed_d = changed_q | (next_row != cur_q[row_q]);
                alive_d   = alive_q | (|next_row);
                if (row_q == LAST_ROW) state_d = COMMIT;
                else                   row_d   = row_q + 1'b1;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            cur_q     <= '{default: '0};
            nxt_q     <= '{default: '0};
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b1;
        end else begin
            if (load_we) cur_q[bus.load_addr] <= bus.load_row;
            if (nxt_we)  nxt_q[row_q]         <= next_row;
            if (commit) begin
                cur_q     <= nxt_q;
                gen_q     <= gen_q + 1'b1;
                stable_q  <= ~changed_q;
                extinct_q <= ~alive_q;
            end
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == COMMIT);
    assign bus.gen_count  = gen_q;
    assign bus.stable     = stable_q;
    assign bus.extinct    = extinct_q;
    assign bus.rd_row     = cur_q[bus.rd_addr];
    assign bus.state      = state_q;

endmodule

// File: tb/tb_cgol_gen_engine.sv
// Directed bench for cgol_gen_engine on an 8x8 grid; expectations for the
// edge-sensitive patterns follow CGOL_TORUS_EN.
module tb_cgol_gen_engine;
    import cgol_pkg::*;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam int CNT_W  = 16;

    logic ph1 = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] exp_g [HEIGHT];

    cgol_gen_engine_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W)) bus ();

    cgol_gen_engine #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    always #10 ph1 = ~ph1;

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input int r, input logic [WIDTH-1:0] exp, input string tag);
        bus.rd_addr = 3'(r);
        #1;
        check(32'(bus.rd_row), 32'(exp), $sformatf("%s_row%0d", tag, r));
    endtask

    task automatic check_grid(input string tag);
        for (int r = 0; r < HEIGHT; r++) check_row(r, exp_g[r], tag);
    endtask

    task automatic check_status(input int gen, input logic stb, input logic ext, input string tag);
        check(32'(bus.gen_count), 32'(gen), {tag, "_gen_count"});
        check(32'(bus.stable), 32'(stb), {tag, "_stable"});
        check(32'(bus.extinct), 32'(ext), {tag, "_extinct"});
    endtask

    task automatic load(input int r, input logic [WIDTH-1:0] v);
        bus.load_valid = 1'b1;
        bus.load_addr  = 3'(r);
        bus.load_row   = v;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic fill(input logic [WIDTH-1:0] v);
        for (int r = 0; r < HEIGHT; r++) load(r, v);
    endtask

    task automatic wait_done(input int n_start, input string tag);
        int n;
        n = n_start;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(32'(n), 32'(HEIGHT + 1), {tag, "_latency"});
        tick();
        check(32'(bus.done), 32'd0, {tag, "_done_pulse"});
        check(32'(bus.busy), 32'd0, {tag, "_busy_clear"});
    endtask

    task automatic run_gen(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check(32'(bus.busy), 32'd1, {tag, "_busy"});
        check(32'(bus.load_ready), 32'd0, {tag, "_load_ready_low"});
        wait_done(1, tag);
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_row   = '0;
        bus.start      = 1'b0;
        bus.rd_addr    = '0;

        // Reset values
        #2 reset = 1'b0;
        tick();
        tick();
        check(32'(bus.busy), 32'd0, "rst_busy");
        check(32'(bus.done), 32'd0, "rst_done");
        check(32'(bus.load_ready), 32'd1, "rst_load_ready");
        check(32'(bus.state), 32'(IDLE), "rst_state");
        check_status(0, 1'b0, 1'b1, "rst");
        exp_g = '{default: '0};
        check_grid("rst");
        reset = 1'b1;
        tick();

        // Blinker, two generations
        load(3, 8'b00011100);
        run_gen("blink1");
        exp_g = '{default: '0};
        exp_g[2] = 8'b00001000;
        exp_g[3] = 8'b00001000;
        exp_g[4] = 8'b00001000;
        check_grid("blink1");
        check_status(1, 1'b0, 1'b0, "blink1");
        run_gen("blink2");
        exp_g = '{default: '0};
        exp_g[3] = 8'b00011100;
        check_grid("blink2");
        check_status(2, 1'b0, 1'b0, "blink2");

        // Still life block
        fill(8'h00);
        load(3, 8'b00011000);
        load(4, 8'b00011000);
        run_gen("block");
        exp_g = '{default: '0};
        exp_g[3] = 8'b00011000;
        exp_g[4] = 8'b00011000;
        check_grid("block");
        check_status(3, 1'b1, 1'b0, "block");

        // All-ones grid
        fill(8'hFF);
        run_gen("ones");
        exp_g = '{default: '0};
`ifdef CGOL_TORUS_EN
        check_grid("ones");
        check_status(4, 1'b0, 1'b1, "ones");
`else
        exp_g[0] = 8'b10000001;
        exp_g[7] = 8'b10000001;
        check_grid("ones");
        check_status(4, 1'b0, 1'b0, "ones");
`endif

        // Pattern straddling the column edges
        fill(8'h00);
        load(3, 8'b10000011);
        run_gen("wrap");
        exp_g = '{default: '0};
`ifdef CGOL_TORUS_EN
        exp_g[2] = 8'b00000001;
        exp_g[3] = 8'b00000001;
        exp_g[4] = 8'b00000001;
        check_grid("wrap");
        check_status(5, 1'b0, 1'b0, "wrap");
`else
        check_grid("wrap");
        check_status(5, 1'b0, 1'b1, "wrap");
`endif

        // Reset during the fourth COMPUTE cycle
        fill(8'h00);
        load(3, 8'b00011100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check(32'(bus.state), 32'(COMPUTE), "midrst_in_compute");
        reset = 1'b0;
        #1;
        check(32'(bus.busy), 32'd0, "midrst_busy");
        check_status(0, 1'b0, 1'b1, "midrst");
        exp_g = '{default: '0};
        check_grid("midrst");
        reset = 1'b1;
        tick();
        check(32'(bus.load_ready), 32'd1, "midrst_load_ready");
        check(32'(bus.state), 32'(IDLE), "midrst_state");

        // Load and start together: load wins
        bus.start      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_addr  = 3'd3;
        bus.load_row   = 8'b00011100;
        tick();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        check(32'(bus.busy), 32'd0, "hs_busy_after_both");
        check_row(3, 8'b00011100, "hs_loaded");

        // Requests during busy are ignored
        bus.start = 1'b1;
        tick();
        check(32'(bus.busy), 32'd1, "hs_busy");
        bus.load_valid = 1'b1;
        bus.load_addr  = 3'd0;
        bus.load_row   = 8'hFF;
        tick();
        tick();
        check_row(0, 8'h00, "hs_ignored_load");
        check(32'(bus.gen_count), 32'd0, "hs_gen_during_busy");
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        wait_done(3, "hs");
        exp_g = '{default: '0};
        exp_g[2] = 8'b00001000;
        exp_g[3] = 8'b00001000;
        exp_g[4] = 8'b00001000;
        check_grid("hs");
        check_status(1, 1'b0, 1'b0, "hs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgol_gen_engine.md
Name: cgol_gen_engine

Overview:
- Parametrised Game of Life generation engine that holds a HEIGHT x WIDTH grid in two register banks: cur and nxt.
- Computes one full generation per start request, one row per cycle, through a 3-row neighbourhood datapath.
- Cells are seeded through a valid/ready row-load port.
- Exposes an asynchronous-read row port for the display scanner, plus per-generation status: generation count, stable and extinct.

Parameters:
WIDTH, 8, columns per row (>=3)
HEIGHT, 8, rows per grid (>=3)
CNT_W, 16, generation counter width

Ports:
ph1  in  1  single system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
load_valid  in  1  row-load request
load_ready  out  1  engine can accept a load
load_addr  in  $clog2(HEIGHT)  row index for load
load_row  in  WIDTH  row data to load; bit 0 = column 0
start  in  1  request one generation
busy  out  1  generation in progress
done  out  1  one-cycle pulse when a generation is committed
gen_count  out  CNT_W  committed generations since reset
stable  out  1  last generation equalled its predecessor
extinct  out  1  last committed grid is all zero
rd_addr  in  $clog2(HEIGHT)  display read row
rd_row  out  WIDTH  cur[rd_addr], combinational

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - cur and nxt cleared; gen_count=0; stable=0; extinct=1; busy=0; done=0; state=IDLE.
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE:
  - load_ready=1.
  - load_valid=1 writes load_row into cur[load_addr] at the edge.
  - Out-of-range load_addr (>=HEIGHT) is dropped.
  - start=1 with load_valid=0 moves to COMPUTE with row counter r=0 and changed/alive accumulators cleared.
  - start and load_valid in the same cycle: load wins and start is discarded.
- COMPUTE:
  - load_ready=0 and busy=1; start and load_valid are ignored.
  - Each cycle: nxt[r] = rule(cur[r-1], cur[r], cur[r+1]).
  - changed |= (nxt[r] != cur[r]); alive |= |nxt[r].
  - At r=HEIGHT-1 go to COMMIT; otherwise r++.
- COMMIT (1 cycle, busy=1):
  - cur <= nxt.
  - gen_count++, wrapping modulo 2^CNT_W.
  - stable <= ~changed; extinct <= ~alive.
  - done=1 for this cycle; next state IDLE.
- Latency: start sampled at edge k makes busy high from k. COMPUTE occupies HEIGHT cycles. done is high in cycle k+HEIGHT, and cur, gen_count and flags update at the edge ending that cycle.
- Earliest next start is accepted in the cycle after done.
- Rule per cell:
  - Neighbour sum is 4 bits wide (0..8); a count of 8 must never alias to 0.
  - Birth when the cell is dead and sum==3.
  - Survival when the cell is alive and sum is 2 or 3.
  - All other cases: dead.
- Boundary handling:
  - Edge rows and columns follow the optional feature below.
  - rd_row always reflects cur, so the display never sees a partially computed grid.
- Reset asserted mid-COMPUTE or mid-COMMIT: the generation is abandoned and all reset values apply.

Optional Feature:
- Macro CGOL_TORUS_EN.
- When defined, the grid is toroidal:
  - row -1 maps to HEIGHT-1 and row HEIGHT maps to 0;
  - column -1 maps to WIDTH-1 and column WIDTH maps to 0.
- When undefined, all out-of-grid neighbours read as dead (finite plane).

Decomposition:
- Package cgol_pkg:
  - state enum type cgol_state_t (IDLE, COMPUTE, COMMIT);
  - constants BIRTH_CNT=3, SURV_LO=2, SURV_HI=3;
  - a 4-bit neighbour-count typedef.
- Sub-module cgol_row_next: purely combinational, parameter WIDTH.
  - Inputs: above, mid, below rows. Output: next row.
  - The column-wrap choice under CGOL_TORUS_EN lives here.
  - Row-wrap selection stays in the engine.

Test Plan:
1. Blinker, 8x8, torus off: load row3=8'b00011100, then start. done arrives 9 cycles after start. Rows 2/3/4 each read 8'b00001000; gen_count=1, stable=0, extinct=0. A second start restores the original grid with gen_count=2.
2. Still life: 2x2 block at rows 3-4, cols 3-4, then start. Grid is unchanged, stable=1, extinct=0.
3. All-ones 8x8 grid:
   - torus on: every cell sees 8 neighbours, all die, extinct=1 (guards sum aliasing);
   - torus off: only the four corners survive (3 neighbours), extinct=0.
4. Column wrap: row3=8'b10000011, then start.
   - Torus on: rows 2/3/4 = 8'b00000001.
   - Torus off: whole grid 0, extinct=1.
5. Reset at COMPUTE cycle 4: all rows read 0, gen_count=0, busy=0, extinct=1. load_ready=1 in the first cycle after release.
6. Handshake: start with load_valid in IDLE means the load is written and busy stays 0. start or load_valid during busy leaves cur and gen_count unaffected until done.
